plic_gateway: RTL and testbench

- Interrupt gateway directly upstream of the PLIC core.
- Converts raw device interrupt lines (UART, disk, keyboard, ...) into one pending request per source, in the form the PLIC pending/claim logic consumes.
- Enforces the PLIC rule that at most one request per source is outstanding until the hart signals completion.
- Level sources re-request while still asserted; edge sources count outstanding edges.

---
 rtl/plic_pkg.sv | 21 ++
 rtl/plic_gateway_src.sv | 108 ++++++++++
 rtl/plic_gateway.sv | 61 ++++++
 tb/tb_plic_gateway.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC interrupt gateway.
package plic_pkg;

  // Per-source gateway state encoding
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PEND     = 2'd1;
  localparam logic [1:0] INFLIGHT = 2'd2;

  typedef enum logic [1:0] {
    StIdle     = IDLE,
    StPend     = PEND,
    StInflight = INFLIGHT
  } src_state_e;

  localparam int unsigned PLIC_N_INT_SRC = 32;
  localparam int unsigned PLIC_ID_W      = $clog2(PLIC_N_INT_SRC);

  // All sources level-triggered unless overridden
  localparam logic [31:0] PLIC_EDGE_MASK = 32'h0;

endpackage

// File: rtl/plic_gateway_src.sv
// One gateway source: input synchronizer, edge history, outstanding-edge counter and
// IDLE/PEND/INFLIGHT state machine.
module plic_gateway_src
  import plic_pkg::*;
#(
  parameter bit          EDGE_MODE   = 1'b0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic inflight,
  output logic edge_ovf
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             s;
  logic             s_prev_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  src_state_e       state_q, state_d;
  logic             pending_q, inflight_q;
  logic             claim_ok, complete_ok;
  logic             inc, dec, req;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = irq;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw line through the synchronizer chain
    always_ff @(posedge CLK) begin
      if (RST) begin
        sync_q <= '0;
      end else begin
        sync_q <= (sync_q << 1) | SYNC_STAGES'(irq);
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  assign rise = s & ~s_prev_q;

  // Next-state, counter and overflow evaluation
  always_comb begin
    claim_ok    = claim && (state_q == StPend);
    complete_ok = complete && (state_q == StInflight);
    inc         = EDGE_MODE && rise;
    dec         = EDGE_MODE && claim_ok;

    cnt_d = cnt_q;
    ovf_d = ovf_q;
    // Coincident edge and claim cancel, so a full counter only drops an edge when
    // no claim is draining it in the same cycle.
    if (inc && !dec) begin
      if (cnt_q == CntMax) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dec && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end

    // A new request exists: level sources look at the line, edge sources at the
    // backlog plus any edge arriving now.
    req = EDGE_MODE ? ((cnt_q != '0) || rise) : s;

    state_d = state_q;
    unique case (state_q)
      StIdle:     if (req) state_d = StPend;
      StPend:     if (claim_ok) state_d = StInflight;
      StInflight: if (complete_ok) state_d = req ? StPend : StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // State, counter, history and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      s_prev_q   <= 1'b0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      pending_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_prev_q   <= s;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      pending_q  <= (state_d == StPend);
      inflight_q <= (state_d == StInflight);
    end
  end

  assign pending  = pending_q;
  assign inflight = inflight_q;
  assign edge_ovf = ovf_q;

endmodule

// File: rtl/plic_gateway.sv
// PLIC interrupt gateway: one request per source, gated by claim/complete handshake.
module plic_gateway
  import plic_pkg::*;
#(
  parameter int unsigned           N_INT_SRC   = PLIC_N_INT_SRC,
  parameter logic [N_INT_SRC-1:0]  EDGE_MASK   = N_INT_SRC'(PLIC_EDGE_MASK),
  parameter int unsigned           SYNC_STAGES = 2,
  parameter int unsigned           CNT_W       = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [N_INT_SRC-1:0]         w_irq_src,
  input  logic                         w_claim,
  input  logic [$clog2(N_INT_SRC)-1:0] w_claim_id,
  input  logic                         w_complete,
  input  logic [$clog2(N_INT_SRC)-1:0] w_complete_id,
  output logic [N_INT_SRC-1:0]         w_pending,
  output logic [N_INT_SRC-1:0]         w_inflight,
  output logic [N_INT_SRC-1:0]         w_edge_ovf
);

  localparam int unsigned IdW = $clog2(N_INT_SRC);

  logic [N_INT_SRC-1:0] claim_vec;
  logic [N_INT_SRC-1:0] complete_vec;
  logic                 unused_src0;

  // Decode IDs to one-hot strobes; ID 0 and out-of-range IDs match no source
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    for (int i = 1; i < int'(N_INT_SRC); i++) begin
      claim_vec[i]    = w_claim && (w_claim_id == IdW'(i));
      complete_vec[i] = w_complete && (w_complete_id == IdW'(i));
    end
  end

  // Source 0 is reserved
  assign unused_src0   = w_irq_src[0] ^ claim_vec[0] ^ complete_vec[0];
  assign w_pending[0]  = 1'b0;
  assign w_inflight[0] = 1'b0;
  assign w_edge_ovf[0] = 1'b0;

  for (genvar i = 1; i < N_INT_SRC; i++) begin : g_src
    plic_gateway_src #(
      .EDGE_MODE  (EDGE_MASK[i]),
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_src (
      .CLK     (CLK),
      .RST     (RST),
      .irq     (w_irq_src[i]),
      .claim   (claim_vec[i]),
      .complete(complete_vec[i]),
      .pending (w_pending[i]),
      .inflight(w_inflight[i]),
      .edge_ovf(w_edge_ovf[i])
    );
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Self-checking bench for plic_gateway: source 3 level, source 5 edge, 2-bit counters.
module tb_plic_gateway;

  localparam int unsigned NSrc = 40;
  localparam int unsigned IdW  = $clog2(NSrc);

  logic            CLK = 1'b0;
  logic            RST;
  logic [NSrc-1:0] w_irq_src;
  logic            w_claim;
  logic [IdW-1:0]  w_claim_id;
  logic            w_complete;
  logic [IdW-1:0]  w_complete_id;
  logic [NSrc-1:0] w_pending;
  logic [NSrc-1:0] w_inflight;
  logic [NSrc-1:0] w_edge_ovf;

  plic_gateway #(
    .N_INT_SRC  (NSrc),
    .EDGE_MASK  (NSrc'(40'h20)),
    .SYNC_STAGES(2),
    .CNT_W      (2)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .w_irq_src    (w_irq_src),
    .w_claim      (w_claim),
    .w_claim_id   (w_claim_id),
    .w_complete   (w_complete),
    .w_complete_id(w_complete_id),
    .w_pending    (w_pending),
    .w_inflight   (w_inflight),
    .w_edge_ovf   (w_edge_ovf)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string           tag;
    logic [NSrc-1:0] p;
    logic [NSrc-1:0] i;
    logic [NSrc-1:0] o;
  } exp_t;

  exp_t            sb_q[$];
  logic [NSrc-1:0] ep, ei, eo;
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic check_eq(input string tag, input logic [NSrc-1:0] obs,
                          input logic [NSrc-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic sb_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", '1, '0);
      return;
    end
    e = sb_q.pop_front();
    check_eq({e.tag, "/pending"}, w_pending, e.p);
    check_eq({e.tag, "/inflight"}, w_inflight, e.i);
    check_eq({e.tag, "/edge_ovf"}, w_edge_ovf, e.o);
  endtask

  // Record the expectation for the coming edge, clock it, then compare
  task automatic step(input string tag);
    exp_t e;
    e.tag = tag;
    e.p   = ep;
    e.i   = ei;
    e.o   = eo;
    sb_q.push_back(e);
    tick();
    sb_pop();
  endtask

  task automatic pulse5();
    w_irq_src[5] = 1'b1;
    tick();
    w_irq_src[5] = 1'b0;
    tick();
  endtask

  task automatic cmd(input logic cl, input logic [IdW-1:0] cl_id,
                     input logic cp, input logic [IdW-1:0] cp_id);
    w_claim       = cl;
    w_claim_id    = cl_id;
    w_complete    = cp;
    w_complete_id = cp_id;
  endtask

  initial begin
    RST       = 1'b1;
    w_irq_src = '0;
    cmd(1'b0, '0, 1'b0, '0);
    ep = '0;
    ei = '0;
    eo = '0;
    idle(2);
    step("reset");
    RST = 1'b0;

    // Level source 3: two-stage latency
    w_irq_src[3] = 1'b1;
    step("lvl_lat1");
    step("lvl_lat2");
    ep[3] = 1'b1;
    step("lvl_pend");
    cmd(1'b1, 6'd3, 1'b0, '0);
    ep[3] = 1'b0; ei[3] = 1'b1;
    step("lvl_claim");
    cmd(1'b0, '0, 1'b1, 6'd3);
    ep[3] = 1'b1; ei[3] = 1'b0;
    step("lvl_cpl_hi");
    cmd(1'b1, 6'd3, 1'b0, '0);
    ep[3] = 1'b0; ei[3] = 1'b1;
    step("lvl_claim2");
    cmd(1'b0, '0, 1'b0, '0);
    w_irq_src[3] = 1'b0;
    step("lvl_drop1");
    step("lvl_drop2");
    cmd(1'b0, '0, 1'b1, 6'd3);
    ei[3] = 1'b0;
    step("lvl_cpl_lo");
    cmd(1'b0, '0, 1'b0, '0);

    // Edge source 5: three pulses queue three requests
    for (int k = 0; k < 3; k++) pulse5();
    idle(2);
    ep[5] = 1'b1;
    step("edge_pend");
    for (int k = 0; k < 3; k++) begin
      cmd(1'b1, 6'd5, 1'b0, '0);
      ep[5] = 1'b0; ei[5] = 1'b1;
      step("edge_claim");
      cmd(1'b0, '0, 1'b1, 6'd5);
      ep[5] = (k < 2); ei[5] = 1'b0;
      step("edge_cpl");
    end
    cmd(1'b0, '0, 1'b0, '0);
    idle(2);
    step("edge_idle");

    // Edge arriving in the same cycle as the claim keeps the count at 1
    pulse5();
    idle(2);
    ep[5] = 1'b1;
    step("coin_pend");
    w_irq_src[5] = 1'b1;
    tick();
    w_irq_src[5] = 1'b0;
    tick();
    cmd(1'b1, 6'd5, 1'b0, '0);
    ep[5] = 1'b0; ei[5] = 1'b1;
    step("coin_claim");
    cmd(1'b0, '0, 1'b1, 6'd5);
    ep[5] = 1'b1; ei[5] = 1'b0;
    step("coin_cpl");
    cmd(1'b1, 6'd5, 1'b0, '0);
    ep[5] = 1'b0; ei[5] = 1'b1;
    step("coin_claim2");
    cmd(1'b0, '0, 1'b1, 6'd5);
    ei[5] = 1'b0;
    step("coin_idle");
    cmd(1'b0, '0, 1'b0, '0);

    // Overflow: four edges into a 2-bit counter, then exactly three drains
    for (int k = 0; k < 4; k++) pulse5();
    idle(2);
    ep[5] = 1'b1; eo[5] = 1'b1;
    step("ovf_set");
    for (int k = 0; k < 3; k++) begin
      cmd(1'b1, 6'd5, 1'b0, '0);
      ep[5] = 1'b0; ei[5] = 1'b1;
      step("ovf_claim");
      cmd(1'b0, '0, 1'b1, 6'd5);
      ep[5] = (k < 2); ei[5] = 1'b0;
      step("ovf_cpl");
    end
    cmd(1'b0, '0, 1'b0, '0);
    step("ovf_drained");

    // Ignored commands
    w_irq_src[3] = 1'b1;
    idle(2);
    ep[3] = 1'b1;
    step("ill_setup");
    cmd(1'b1, 6'd0, 1'b0, '0);
    step("ill_claim0");
    cmd(1'b1, 6'd40, 1'b0, '0);
    step("ill_claim40");
    cmd(1'b0, '0, 1'b1, 6'd5);
    step("ill_cpl_idle");
    cmd(1'b0, '0, 1'b1, 6'd3);
    step("ill_cpl_pend");
    cmd(1'b0, '0, 1'b0, '0);
    pulse5();
    ep[5] = 1'b1;
    step("ill_p5");
    cmd(1'b1, 6'd5, 1'b0, '0);
    ep[5] = 1'b0; ei[5] = 1'b1;
    step("ill_claim5");
    cmd(1'b1, 6'd3, 1'b1, 6'd5);
    ep[3] = 1'b0; ei[3] = 1'b1; ei[5] = 1'b0;
    step("dual_cmd");
    cmd(1'b0, '0, 1'b0, '0);

    // Reset mid-flight: source 3 in flight, source 5 holding two edges
    pulse5();
    pulse5();
    ep[5] = 1'b1;
    step("pre_rst");
    RST = 1'b1;
    ep = '0; ei = '0; eo = '0;
    step("rst_mid");
    RST = 1'b0;
    step("rst_rel1");
    step("rst_rel2");
    ep[3] = 1'b1;
    step("rst_repend");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
